// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-size derivation, round constants,
// controller state encoding and the forward S-box.
package aes_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam logic [7:0]  RCON_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } ks_state_e;

    function automatic int unsigned nk_of(input int unsigned x);
        return 4 + 2 * x;
    endfunction

    function automatic int unsigned nr_of(input int unsigned x);
        return 10 + 2 * x;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/key_sub_word.sv
// SubWord: the AES S-box applied independently to each byte of a 32-bit word.
module key_sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o
);

    always_comb begin
        word_o = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
        end
    end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one 32-bit schedule word per clock,
// holding the finished schedule with done asserted until the next start.
module key_schedule_seq
    import aes_pkg::*;
#(
    parameter int unsigned x = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [0:128+64*x-1]          key,
    output logic [0:128*(2*x+11)-1]      words,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned NK   = nk_of(x);
    localparam int unsigned NR   = nr_of(x);
    localparam int unsigned NW   = 4 * NR + 4;
    localparam int unsigned IW   = $clog2(NW);

    ks_state_e          state_q, state_d;
    logic [WORD_W-1:0]  w_q   [NW];
    logic [WORD_W-1:0]  w_d   [NW];
    logic [WORD_W-1:0]  win_q [NK];
    logic [WORD_W-1:0]  win_d [NK];
    logic [IW-1:0]      i_q, i_d;
    logic [2:0]         imod_q, imod_d;
    logic [7:0]         rcon_q, rcon_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WORD_W-1:0]  last_w, sub_in, sub_out, temp, new_w;

    // win_q[0] is w[i-Nk], win_q[NK-1] is w[i-1]
    assign last_w = win_q[NK-1];
    assign sub_in = (imod_q == 3'd0) ? {last_w[23:0], last_w[31:24]} : last_w;

    key_sub_word u_sub (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        if (imod_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && imod_q == 3'd4) begin
            temp = sub_out;
        end else begin
            temp = last_w;
        end
        new_w = win_q[0] ^ temp;
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        win_d   = win_q;
        i_d     = i_q;
        imod_d  = imod_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // words at index >= NK keep stale contents until rewritten
                    for (int unsigned j = 0; j < NK; j++) begin
                        w_d[j]   = key[32*j +: 32];
                        win_d[j] = key[32*j +: 32];
                    end
                    i_d     = IW'(NK);
                    imod_d  = '0;
                    rcon_d  = RCON_INIT;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_d[i_q] = new_w;
                for (int unsigned j = 0; j < NK - 1; j++) begin
                    win_d[j] = win_q[j+1];
                end
                win_d[NK-1] = new_w;
                i_d    = i_q + 1'b1;
                imod_d = (imod_q == 3'(NK - 1)) ? 3'd0 : imod_q + 3'd1;
                if (imod_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == IW'(NW - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            w_q     <= '{default: '0};
            win_q   <= '{default: '0};
            i_q     <= '0;
            imod_q  <= '0;
            rcon_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            win_q   <= win_d;
            i_q     <= i_d;
            imod_q  <= imod_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        words = '0;
        for (int unsigned j = 0; j < NW; j++) begin
            words[32*j +: 32] = w_q[j];
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq: one instance per key size, FIPS-197 vectors.
module tb_key_schedule_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [0:127]  key0 = '0;
    logic [0:191]  key1 = '0;
    logic [0:255]  key2 = '0;
    logic [0:1407] words0;
    logic [0:1663] words1;
    logic [0:1919] words2;
    logic busy0, busy1, busy2, done0, done1, done2;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] KEY_C = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY_D = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    key_schedule_seq #(.x(0)) dut0 (.clk(clk), .rst(rst), .start(start0), .key(key0),
                                    .words(words0), .busy(busy0), .done(done0));
    key_schedule_seq #(.x(1)) dut1 (.clk(clk), .rst(rst), .start(start1), .key(key1),
                                    .words(words1), .busy(busy1), .done(done1));
    key_schedule_seq #(.x(2)) dut2 (.clk(clk), .rst(rst), .start(start2), .key(key2),
                                    .words(words2), .busy(busy2), .done(done2));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic sel_done(input int unsigned which);
        case (which)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic sel_busy(input int unsigned which);
        case (which)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic drive(input int unsigned which, input logic s, input logic [255:0] k);
        case (which)
            0: begin start0 = s; key0 = k[127:0]; end
            1: begin start1 = s; key1 = k[191:0]; end
            default: begin start2 = s; key2 = k; end
        endcase
    endtask

    // Pulse start, then count edges (start edge = 1) until done; optionally
    // inject a second start with another key at edge count inj_at.
    task automatic run(input int unsigned which, input logic [255:0] k,
                       input int unsigned inj_at, input logic [255:0] inj_key,
                       output int unsigned cyc);
        @(negedge clk);
        drive(which, 1'b1, k);
        @(posedge clk); #1;
        drive(which, 1'b0, ~k);
        cyc = 1;
        check($sformatf("start_busy%0d", which), 128'(sel_busy(which)), 128'd1);
        check($sformatf("start_done%0d", which), 128'(sel_done(which)), 128'd0);
        while (!sel_done(which) && cyc < 200) begin
            if (cyc == inj_at) begin
                @(negedge clk);
                drive(which, 1'b1, inj_key);
            end
            @(posedge clk); #1;
            drive(which, 1'b0, ~k);
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;

        #12;
        check("rst_words0", 128'(|words0), 128'd0);
        check("rst_words2", 128'(|words2), 128'd0);
        check("rst_busy0", 128'(busy0), 128'd0);
        check("rst_done0", 128'(done0), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // AES-128
        run(0, 256'(KEY_A), 0, '0, cyc);
        check("x0_latency", 128'(cyc), 128'd41);
        check("x0_w4", 128'(words0[128 +: 32]), 128'ha0fafe17);
        check("x0_rk10", words0[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("x0_rk0", words0[0 +: 128], KEY_A);
        check("x0_busy_end", 128'(busy0), 128'd0);

        // AES-192
        run(1, 256'(KEY_C), 0, '0, cyc);
        check("x1_latency", 128'(cyc), 128'd47);
        check("x1_w6", 128'(words1[32*6 +: 32]), 128'hfe0c91f7);
        check("x1_w51", 128'(words1[32*51 +: 32]), 128'h01002202);

        // AES-256
        run(2, KEY_D, 0, '0, cyc);
        check("x2_latency", 128'(cyc), 128'd53);
        check("x2_w8", 128'(words2[32*8 +: 32]), 128'h9ba35411);
        check("x2_w12", 128'(words2[32*12 +: 32]), 128'ha8b09c1a);
        check("x2_w59", 128'(words2[32*59 +: 32]), 128'h706c631e);

        // start during EXPAND must be ignored
        run(0, 256'(KEY_A), 11, 256'(KEY_B), cyc);
        check("ign_latency", 128'(cyc), 128'd41);
        check("ign_rk10", words0[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("ign_rk0", words0[0 +: 128], KEY_A);

        // asynchronous reset mid-expansion
        @(negedge clk);
        drive(0, 1'b1, 256'(KEY_B));
        @(posedge clk); #1;
        drive(0, 1'b0, 256'(KEY_B));
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_words0", 128'(|words0), 128'd0);
        check("arst_busy0", 128'(busy0), 128'd0);
        check("arst_done0", 128'(done0), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        run(0, 256'(KEY_A), 0, '0, cyc);
        check("post_rst_latency", 128'(cyc), 128'd41);
        check("post_rst_rk10", words0[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // restart from DONE with a new key
        run(0, 256'(KEY_B), 0, '0, cyc);
        check("restart_latency", 128'(cyc), 128'd41);
        check("restart_rk10", words0[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("restart_rk0", words0[0 +: 128], KEY_B);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
